rob_commit_ctrl: RTL and testbench

//  In-order retirement scheduler for the out-of-order core. It is a circular reorder queue:
//   - allocates one tag per decoded instruction;
//   - captures results from the CDB;
//   - retires the head entry into the register file over the rf_* port (rd/value/tag).
//  On a mispredicted branch at the head it raises a one-cycle flush and empties itself.

---
 rtl/rob_commit_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rob_commit_ctrl
//  Purpose  : In-order retirement scheduler built as a circular reorder
//             queue. Allocates one tag per decoded instruction, captures
//             results from the CDB and retires the head entry into the
//             register file. A mispredicted branch at the head raises a
//             one-cycle flush and empties the queue.
//  Ports    :
//    clk_in, rst_in, rdy_in       clock, sync active-high reset, global enable
//    dec_*                        decoder allocation request and entry fields
//    rob_full, alloc_tag          combinational: queue full, tag for dec_valid
//    cdb_*                        result broadcast (tag/value/branch outcome)
//    rf_valid/rd/value/dependency registered retire write of the head entry
//    need_flush_out, flush_pc_out registered one-cycle redirect pulse + PC
//  Revision : 1.0  initial release
// ============================================================================
module rob_commit_ctrl #(
   parameter int ROB_SIZE_WIDTH = 4,
   parameter int REG_NUM_WIDTH  = 5
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic                      dec_valid,
   input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
   input  logic                      dec_is_branch,
   input  logic                      dec_pred_taken,
   input  logic [31:0]               dec_alt_pc,
   output logic                      rob_full,
   output logic [ROB_SIZE_WIDTH-1:0] alloc_tag,
   input  logic                      cdb_valid,
   input  logic [ROB_SIZE_WIDTH-1:0] cdb_tag,
   input  logic [31:0]               cdb_value,
   input  logic                      cdb_taken,
   output logic                      rf_valid,
   output logic [REG_NUM_WIDTH-1:0]  rf_rd,
   output logic [31:0]               rf_value,
   output logic [ROB_SIZE_WIDTH-1:0] rf_dependency,
   output logic                      need_flush_out,
   output logic [31:0]               flush_pc_out
);

   localparam int DEPTH = 2 ** ROB_SIZE_WIDTH;
   localparam int CW    = ROB_SIZE_WIDTH + 1;

   // Queue pointers and occupancy
   logic [ROB_SIZE_WIDTH-1:0] head_q, head_d;
   logic [ROB_SIZE_WIDTH-1:0] tail_q, tail_d;
   logic [CW-1:0]             count_q, count_d;

   // Per-entry state
   logic [DEPTH-1:0]          busy_q;
   logic [DEPTH-1:0]          ready_q;
   logic [DEPTH-1:0]          br_q;
   logic [DEPTH-1:0]          pred_q;
   logic [DEPTH-1:0]          taken_q;
   logic [REG_NUM_WIDTH-1:0]  rd_q  [DEPTH];
   logic [31:0]               alt_q [DEPTH];
   logic [31:0]               val_q [DEPTH];

   // Registered outputs
   logic                      rf_valid_q;
   logic [REG_NUM_WIDTH-1:0]  rf_rd_q;
   logic [31:0]               rf_value_q;
   logic [ROB_SIZE_WIDTH-1:0] rf_dep_q;
   logic                      need_flush_q;
   logic [31:0]               flush_pc_q;

   // Per-cycle decisions
   logic do_commit;
   logic mispredict;
   logic do_alloc;
   logic do_wb;

   assign rob_full       = (count_q == CW'(DEPTH));
   assign alloc_tag      = tail_q;
   assign rf_valid       = rf_valid_q;
   assign rf_rd          = rf_rd_q;
   assign rf_value       = rf_value_q;
   assign rf_dependency  = rf_dep_q;
   assign need_flush_out = need_flush_q;
   assign flush_pc_out   = flush_pc_q;

   always_comb begin
      // Commit looks only at the registered ready bit, so a CDB result
      // reaches the register file two cycles after its broadcast.
      do_commit  = busy_q[head_q] && ready_q[head_q];
      mispredict = do_commit && br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
      // A full queue blocks allocation even when a commit frees a slot now.
      do_alloc   = dec_valid && !rob_full && !need_flush_q;
      do_wb      = cdb_valid && busy_q[cdb_tag] && !need_flush_q;

      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (mispredict) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_commit) head_d = head_q + 1'b1;
         if (do_alloc)  tail_d = tail_q + 1'b1;
         count_d = count_q + {{(CW-1){1'b0}}, do_alloc} - {{(CW-1){1'b0}}, do_commit};
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         busy_q       <= '0;
         ready_q      <= '0;
         rf_valid_q   <= 1'b0;
         rf_rd_q      <= '0;
         rf_value_q   <= '0;
         rf_dep_q     <= '0;
         need_flush_q <= 1'b0;
         flush_pc_q   <= '0;
      end else if (rdy_in) begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;

         // Branches retire silently; only non-branch commits write the RF.
         rf_valid_q <= do_commit && !br_q[head_q];
         if (do_commit && !br_q[head_q]) begin
            rf_rd_q    <= rd_q[head_q];
            rf_value_q <= val_q[head_q];
            rf_dep_q   <= head_q;
         end

         need_flush_q <= mispredict;
         if (mispredict) flush_pc_q <= alt_q[head_q];

         if (mispredict) begin
            // Same-cycle allocation and writeback are discarded with the flush.
            busy_q  <= '0;
            ready_q <= '0;
         end else begin
            if (do_wb) begin
               ready_q[cdb_tag] <= 1'b1;
               val_q[cdb_tag]   <= cdb_value;
               taken_q[cdb_tag] <= cdb_taken;
            end
            if (do_commit) begin
               busy_q[head_q]  <= 1'b0;
               ready_q[head_q] <= 1'b0;
            end
            // tail never equals head here while head is busy: that would mean
            // full, which blocks allocation.
            if (do_alloc) begin
               busy_q[tail_q]  <= 1'b1;
               ready_q[tail_q] <= 1'b0;
               rd_q[tail_q]    <= dec_rd;
               br_q[tail_q]    <= dec_is_branch;
               pred_q[tail_q]  <= dec_pred_taken;
               alt_q[tail_q]   <= dec_alt_pc;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rob_commit_ctrl
//  Purpose  : Self-checking bench for rob_commit_ctrl. A queue-based model
//             predicts every output each cycle; directed scenarios add
//             literal expectations at key points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rob_commit_ctrl;

   logic        clk = 1'b0;
   logic        rst_in, rdy_in;
   logic        dec_valid, dec_is_branch, dec_pred_taken;
   logic [4:0]  dec_rd;
   logic [31:0] dec_alt_pc;
   logic        rob_full;
   logic [3:0]  alloc_tag;
   logic        cdb_valid, cdb_taken;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        rf_valid;
   logic [4:0]  rf_rd;
   logic [31:0] rf_value;
   logic [3:0]  rf_dependency;
   logic        need_flush_out;
   logic [31:0] flush_pc_out;

   rob_commit_ctrl #(.ROB_SIZE_WIDTH(4), .REG_NUM_WIDTH(5)) dut (
      .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
      .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_is_branch(dec_is_branch),
      .dec_pred_taken(dec_pred_taken), .dec_alt_pc(dec_alt_pc),
      .rob_full(rob_full), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
      .rf_valid(rf_valid), .rf_rd(rf_rd), .rf_value(rf_value), .rf_dependency(rf_dependency),
      .need_flush_out(need_flush_out), .flush_pc_out(flush_pc_out)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit [4:0]  rd;
      bit        br;
      bit        pred;
      bit [31:0] alt;
      bit [31:0] val;
      bit        taken;
      bit        rdy;
   } ent_t;

   ent_t      mq[$];
   int        mhead = 0;
   bit        e_rfv = 0;
   bit [4:0]  e_rd = 0;
   bit [31:0] e_val = 0;
   bit [3:0]  e_dep = 0;
   bit        e_fl = 0;
   bit [31:0] e_pc = 0;

   bit   m_commit, m_mis, m_alloc, m_flushing;
   int   m_idx;
   ent_t m_h, m_n;

   always @(posedge clk) begin
      if (rst_in) begin
         mq.delete();
         mhead = 0;
         e_rfv = 0; e_rd = 0; e_val = 0; e_dep = 0; e_fl = 0; e_pc = 0;
      end else if (rdy_in) begin
         m_flushing = e_fl;
         m_commit   = (mq.size() > 0) && mq[0].rdy;
         m_mis      = 1'b0;
         m_h        = '{default: 0};
         if (m_commit) begin
            m_h   = mq[0];
            m_mis = m_h.br && (m_h.taken != m_h.pred);
         end
         m_alloc = dec_valid && (mq.size() < 16) && !m_flushing;

         e_rfv = m_commit && !m_h.br;
         if (e_rfv) begin
            e_rd  = m_h.rd;
            e_val = m_h.val;
            e_dep = 4'(mhead);
         end
         e_fl = m_mis;
         if (m_mis) e_pc = m_h.alt;

         if (m_mis) begin
            mq.delete();
            mhead = 0;
         end else begin
            if (cdb_valid && !m_flushing) begin
               m_idx = (int'(cdb_tag) - mhead + 16) % 16;
               if (m_idx < mq.size()) begin
                  mq[m_idx].rdy   = 1'b1;
                  mq[m_idx].val   = cdb_value;
                  mq[m_idx].taken = cdb_taken;
               end
            end
            if (m_commit) begin
               void'(mq.pop_front());
               mhead = (mhead + 1) % 16;
            end
            if (m_alloc) begin
               m_n = '{rd: dec_rd, br: dec_is_branch, pred: dec_pred_taken,
                       alt: dec_alt_pc, val: 0, taken: 0, rdy: 0};
               mq.push_back(m_n);
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rob_full", rob_full, 32'(mq.size() == 16));
         chk("alloc_tag", alloc_tag, 32'((mhead + mq.size()) % 16));
         chk("rf_valid", rf_valid, e_rfv);
         if (e_rfv) begin
            chk("rf_rd", rf_rd, e_rd);
            chk("rf_value", rf_value, e_val);
            chk("rf_dependency", rf_dependency, e_dep);
         end
         chk("need_flush", need_flush_out, e_fl);
         if (e_fl) chk("flush_pc", flush_pc_out, e_pc);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dec_valid = 0; dec_rd = 0; dec_is_branch = 0; dec_pred_taken = 0; dec_alt_pc = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_taken = 0;
   endtask

   task automatic do_reset();
      idle();
      rst_in = 1; tick(); tick();
      rst_in = 0;
   endtask

   task automatic alloc(input bit [4:0] rd, input bit br, input bit pred, input bit [31:0] alt);
      dec_valid = 1; dec_rd = rd; dec_is_branch = br; dec_pred_taken = pred; dec_alt_pc = alt;
   endtask

   task automatic cdb(input bit [3:0] tag, input bit [31:0] val, input bit tk);
      cdb_valid = 1; cdb_tag = tag; cdb_value = val; cdb_taken = tk;
   endtask

   initial begin
      rst_in = 1; rdy_in = 1; idle();
      tick();
      chk_en = 1;
      do_reset();
      chk("reset rf_valid", rf_valid, 0);
      chk("reset flush", need_flush_out, 0);
      chk("reset alloc_tag", alloc_tag, 0);

      // 1: single alloc, CDB next cycle, retire two cycles after CDB
      alloc(5, 0, 0, 0);
      chk("t1 alloc_tag", alloc_tag, 0);
      tick(); idle();
      cdb(0, 32'h1234, 0);
      tick(); idle();
      chk("t1 rf_valid early", rf_valid, 0);
      tick();
      chk("t1 rf_valid", rf_valid, 1);
      chk("t1 rf_rd", rf_rd, 5);
      chk("t1 rf_value", rf_value, 32'h1234);
      chk("t1 rf_dep", rf_dependency, 0);

      // 2: out-of-order CDB, in-order retire
      do_reset();
      for (int i = 1; i <= 3; i++) begin alloc(5'(i), 0, 0, 0); tick(); end
      idle();
      cdb(2, 32'h22, 0); tick();
      cdb(1, 32'h11, 0); tick();
      cdb(0, 32'h10, 0); tick(); idle();
      chk("t2 pre", rf_valid, 0);
      tick(); chk("t2 rd0", rf_rd, 1); chk("t2 dep0", rf_dependency, 0);
      tick(); chk("t2 rd1", rf_rd, 2); chk("t2 val1", rf_value, 32'h11);
      tick(); chk("t2 rd2", rf_rd, 3); chk("t2 val2", rf_value, 32'h22);
      tick(); chk("t2 done", rf_valid, 0);

      // 3: fill to 16, drop 17th, wrap
      do_reset();
      for (int i = 0; i < 16; i++) begin alloc(5'(i), 0, 0, 0); tick(); end
      chk("t3 full", rob_full, 1);
      alloc(31, 0, 0, 0); tick(); idle();
      chk("t3 still full", rob_full, 1);
      cdb(0, 32'hA0, 0); tick(); idle();
      tick();
      chk("t3 not full", rob_full, 0);
      chk("t3 wrap tag", alloc_tag, 0);
      alloc(7, 0, 0, 0); tick(); idle();
      chk("t3 full again", rob_full, 1);
      cdb(1, 32'hA1, 0); tick(); tick();
      chk("t3 rd1 kept", rf_rd, 1);

      // 4: mispredict flush
      do_reset();
      alloc(0, 1, 0, 32'h80); tick();
      alloc(9, 0, 0, 0); tick(); idle();
      cdb(0, 0, 1); tick();
      cdb(1, 32'h99, 0); tick(); idle();
      alloc(3, 0, 0, 0); cdb(0, 32'h55, 0);
      chk("t4 flush", need_flush_out, 1);
      chk("t4 flush_pc", flush_pc_out, 32'h80);
      chk("t4 no rf", rf_valid, 0);
      tick(); idle();
      chk("t4 flush drop", need_flush_out, 0);
      chk("t4 tag0", alloc_tag, 0);
      alloc(4, 0, 0, 0); tick(); idle();
      chk("t4 tag1", alloc_tag, 1);

      // 5: correct-predicted branch retires silently
      do_reset();
      alloc(0, 1, 1, 32'h40); tick();
      alloc(6, 0, 0, 0); tick(); idle();
      cdb(1, 32'h66, 0); tick();
      cdb(0, 0, 1); tick(); idle();
      tick();
      chk("t5 no rf", rf_valid, 0);
      chk("t5 no flush", need_flush_out, 0);
      tick();
      chk("t5 rf", rf_valid, 1);
      chk("t5 rd", rf_rd, 6);
      chk("t5 dep", rf_dependency, 1);

      // 6: rdy_in freeze
      do_reset();
      alloc(3, 0, 0, 0); tick(); idle();
      cdb(0, 32'h33, 0); tick(); idle();
      rdy_in = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6 frozen rf", rf_valid, 0);
         chk("t6 frozen tag", alloc_tag, 1);
      end
      rdy_in = 1;
      tick();
      chk("t6 rf", rf_valid, 1);
      chk("t6 rd", rf_rd, 3);
      chk("t6 val", rf_value, 32'h33);
      tick();

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
